// File: rtl/note_seq_ctrl.sv
// Record/playback note sequencer: captures one note per record press
// and replays the stored notes at a fixed note rate, one-shot or looped.
module note_seq_ctrl #(
    parameter int ADDR_W         = 4,
    parameter int TICKS_PER_NOTE = 25000000,
    parameter int TICK_W         = 25
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load_n,
    input  logic              i_playback_n,
    input  logic              i_stop_n,
    input  logic              i_clear_n,
    input  logic              i_loop_en,
    output logic              o_ld_note,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_ld_play,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_note_start,
    output logic [ADDR_W:0]   o_note_count,
    output logic              o_full
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REC_STROBE = 2'd1,
        REC_HOLD   = 2'd2,
        PLAY       = 2'd3
    } state_t;

    localparam logic [TICK_W-1:0] RELOAD = TICK_W'(TICKS_PER_NOTE - 1);
    localparam logic [ADDR_W:0]   DEPTH  = (ADDR_W+1)'(1) << ADDR_W;

    state_t              r_state;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [TICK_W-1:0]   r_tick;
    logic                r_start;

    state_t              w_nstate;
    logic [ADDR_W:0]     w_count_n;
    logic [ADDR_W-1:0]   w_rd_n;
    logic [TICK_W-1:0]   w_tick_n;
    logic                w_start_n;
    logic [ADDR_W:0]     w_rd_inc;
    logic                w_full;

    assign w_full   = (r_count == DEPTH);
    assign w_rd_inc = {1'b0, r_rd_addr} + (ADDR_W+1)'(1);

    always_comb begin
        w_nstate  = r_state;
        w_count_n = r_count;
        w_rd_n    = r_rd_addr;
        w_tick_n  = r_tick;
        w_start_n = 1'b0;
        o_ld_note = 1'b0;
        o_wr_addr = '0;
        o_ld_play = 1'b0;
        case (r_state)
            IDLE: begin
                if (!i_load_n) begin
                    w_nstate = w_full ? REC_HOLD : REC_STROBE;
                end else if (!i_playback_n && r_count != '0) begin
                    w_nstate  = PLAY;
                    w_rd_n    = '0;
                    w_tick_n  = RELOAD;
                    w_start_n = 1'b1;
                end else if (!i_clear_n) begin
                    w_count_n = '0;
                end
            end
            REC_STROBE: begin
                o_ld_note = 1'b1;
                o_wr_addr = r_count[ADDR_W-1:0];
                if (!w_full) w_count_n = r_count + (ADDR_W+1)'(1);
                w_nstate = REC_HOLD;
            end
            REC_HOLD: begin
                if (i_load_n) w_nstate = IDLE;
            end
            PLAY: begin
                o_ld_play = 1'b1;
                // stop wins over a coincident tick
                if (!i_stop_n) begin
                    w_nstate = IDLE;
                    w_rd_n   = '0;
                end else if (r_tick == '0) begin
                    if (w_rd_inc < r_count) begin
                        w_rd_n    = w_rd_inc[ADDR_W-1:0];
                        w_tick_n  = RELOAD;
                        w_start_n = 1'b1;
                    end else if (i_loop_en) begin
                        w_rd_n    = '0;
                        w_tick_n  = RELOAD;
                        w_start_n = 1'b1;
                    end else begin
                        w_nstate = IDLE;
                        w_rd_n   = '0;
                    end
                end else begin
                    w_tick_n = r_tick - TICK_W'(1);
                end
            end
            default: w_nstate = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_rd_addr <= '0;
            r_tick    <= '0;
            r_start   <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_count   <= w_count_n;
            r_rd_addr <= w_rd_n;
            r_tick    <= w_tick_n;
            r_start   <= w_start_n;
        end
    end

    assign o_rd_addr    = r_rd_addr;
    assign o_note_start = r_start;
    assign o_note_count = r_count;
    assign o_full       = w_full;

endmodule

// File: doc/note_seq_ctrl.md
Name: note_seq_ctrl

Overview:
- Parametrised record/playback sequencer for the music device top level.
- Records up to 2**ADDR_W notes, one per debounced load_n press, and issues write strobes and addresses to an external note RAM.
- Plays notes back in order at a programmable note rate. Supports one-shot or loop mode, stop, and clear.
- Sits between the push-button inputs and the note RAM / tone generator. Owns its own note-rate divider.

Parameters:
- ADDR_W, 4, note RAM address width; depth = 2**ADDR_W notes.
- TICKS_PER_NOTE, 25000000, clk cycles each note is held during playback; must be >= 1.
- TICK_W, 25, width of the note-rate counter; must satisfy 2**TICK_W > TICKS_PER_NOTE-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load_n  in  1  record button, active-low level
- playback_n  in  1  play button, active-low level
- stop_n  in  1  stop button, active-low level
- clear_n  in  1  erase-recording button, active-low level
- loop_en  in  1  1 = loop playback, 0 = one-shot; sampled at each wrap point
- ld_note  out  1  one-cycle write strobe to note RAM
- wr_addr  out  ADDR_W  write address, valid while ld_note=1
- ld_play  out  1  high for the whole PLAY state
- rd_addr  out  ADDR_W  current playback address
- note_start  out  1  one-cycle pulse when rd_addr presents a new note
- note_count  out  ADDR_W+1  number of notes recorded
- full  out  1  note_count == 2**ADDR_W

Behaviour:
- Reset: when reset=1 at a clk edge, the block goes to IDLE and forces note_count=0, rd_addr=0, tick counter=0. All outputs then read 0: ld_note, ld_play, note_start, wr_addr, full. Reset has priority over all inputs in every state, including mid-playback.
- State IDLE:
  - load_n=0 and !full -> REC_STROBE.
  - load_n=0 and full -> REC_HOLD; no write occurs.
  - Otherwise, playback_n=0 and note_count>0 -> PLAY.
  - Otherwise, clear_n=0 -> note_count<=0; stay in IDLE.
  - Otherwise stay in IDLE.
  - Priority is load > playback > clear. playback_n=0 with note_count=0 is ignored.
- State REC_STROBE:
  - Lasts exactly 1 cycle.
  - ld_note=1 and wr_addr=note_count[ADDR_W-1:0].
  - note_count<=note_count+1 at the end of the cycle.
  - Always -> REC_HOLD.
- State REC_HOLD:
  - Waits for release of the record button.
  - load_n=1 -> IDLE; otherwise stay.
  - Holding load_n records exactly one note.
- Entering PLAY:
  - rd_addr<=0 and tick counter<=TICKS_PER_NOTE-1.
  - note_start=1 during the first PLAY cycle.
- State PLAY, ld_play=1:
  - The tick counter decrements each cycle.
  - A tick is declared when the counter reads 0.
  - On a tick with rd_addr < note_count-1: rd_addr<=rd_addr+1, counter reloads, and note_start pulses in the next cycle.
  - On a tick with rd_addr == note_count-1 and loop_en=1: rd_addr<=0, counter reloads, and note_start pulses in the next cycle.
  - On a tick with rd_addr == note_count-1 and loop_en=0: go to IDLE, rd_addr<=0.
  - Each note is therefore presented for exactly TICKS_PER_NOTE cycles.
  - stop_n=0 -> IDLE next cycle with rd_addr<=0. stop has priority over the tick.
  - load_n, clear_n and playback_n are ignored in PLAY.
- TICKS_PER_NOTE=1: a tick occurs every PLAY cycle, so rd_addr advances every cycle.
- full is combinational from note_count. note_count saturates at 2**ADDR_W and never wraps.
- wr_addr is driven to 0 outside REC_STROBE.
- The state register is 2 bits; unused encodings go to IDLE.
- Inputs are assumed already synchronised and debounced upstream.

Test Plan (ADDR_W=2, TICKS_PER_NOTE=4 unless stated):
- Reset, then 3 load_n presses, each 5 cycles low and 2 high -> ld_note pulses once per press with wr_addr=0,1,2; note_count=3; full=0.
- 5 presses after reset -> 4 strobes at wr_addr 0..3; the 5th press gives no strobe; note_count=4; full=1.
- 3 notes recorded, loop_en=0, playback_n pulsed -> ld_play high for 12 cycles; rd_addr=0,0,0,0,1,1,1,1,2,2,2,2; note_start on cycles 1, 5, 9; then IDLE with rd_addr=0.
- Same with loop_en=1 -> rd_addr wraps 2->0 at cycle 13 with a note_start pulse. Then stop_n=0 mid-note -> ld_play=0 the next cycle and rd_addr=0.
- playback_n=0 with note_count=0 -> stays IDLE, ld_play=0. clear_n=0 after 2 recordings -> note_count=0. load_n and playback_n low in the same cycle -> record wins.
- reset=1 during PLAY at rd_addr=2 -> next cycle all outputs 0 and note_count=0. TICKS_PER_NOTE=1 build -> rd_addr advances every cycle.
